// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================================
// Module      : sad_min_search
// Description : Scans the SAD result memory once per Go and reports the
//               minimum SAD value and the lowest address holding it.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_min_search #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 128
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Go,
    output logic [ADDR_W-1:0] C_Addr,
    output logic              C_RW,
    output logic              C_En,
    input  logic [DATA_W-1:0] C_Data,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Min_SAD,
    output logic [ADDR_W-1:0] Min_Idx
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } t_state;

    t_state            r_state;
    t_state            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_daddr;
    logic              r_dvalid;
    logic [DATA_W-1:0] r_run_min;
    logic [ADDR_W-1:0] r_run_idx;
    logic [DATA_W-1:0] r_min_sad;
    logic [ADDR_W-1:0] r_min_idx;
    logic              w_hit;
    logic [DATA_W-1:0] w_cand_min;
    logic [ADDR_W-1:0] w_cand_idx;

    // Strict compare: equal values never displace an earlier (lower) index.
    assign w_hit      = r_dvalid && (C_Data < r_run_min);
    assign w_cand_min = w_hit ? C_Data  : r_run_min;
    assign w_cand_idx = w_hit ? r_daddr : r_run_idx;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Go) w_state_next = S_ISSUE;
            S_ISSUE: if (r_addr == C_LAST_ADDR) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_daddr   <= '0;
            r_dvalid  <= 1'b0;
            r_run_min <= '0;
            r_run_idx <= '0;
            r_min_sad <= '0;
            r_min_idx <= '0;
        end else begin
            r_state  <= w_state_next;
            r_dvalid <= (r_state == S_ISSUE);
            r_daddr  <= r_addr;
            if (w_hit) begin
                r_run_min <= C_Data;
                r_run_idx <= r_daddr;
            end
            case (r_state)
                S_IDLE: begin
                    if (Go) begin
                        r_addr    <= '0;
                        r_run_min <= '1;
                        r_run_idx <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_addr != C_LAST_ADDR) r_addr <= r_addr + 1'b1;
                end
                S_DRAIN: begin
                    // Last word's compare lands on this edge; publish its outcome directly.
                    r_min_sad <= w_cand_min;
                    r_min_idx <= w_cand_idx;
                end
                default: ;
            endcase
        end
    end

    assign C_Addr  = r_addr;
    assign C_RW    = 1'b0;
    assign C_En    = (r_state == S_ISSUE);
    assign Busy    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign Done    = (r_state == S_DONE);
    assign Min_SAD = r_min_sad;
    assign Min_Idx = r_min_idx;

endmodule
`default_nettype wire

// File: tb/tb_sad_min_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_min_search
// Description : Self-checking bench for sad_min_search with a memory model
//               and a plain-loop minimum reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_min_search;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int N      = 128;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Go  = 1'b0;
    logic [ADDR_W-1:0] C_Addr;
    logic              C_RW;
    logic              C_En;
    logic [DATA_W-1:0] C_Data = '0;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Min_SAD;
    logic [ADDR_W-1:0] Min_Idx;

    logic [DATA_W-1:0] mem [N];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (C_En) C_Data <= mem[C_Addr];

    sad_min_search #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ENTRIES(N)) dut (
        .Clk(Clk), .Rst(Rst), .Go(Go), .C_Addr(C_Addr), .C_RW(C_RW), .C_En(C_En),
        .C_Data(C_Data), .Busy(Busy), .Done(Done), .Min_SAD(Min_SAD), .Min_Idx(Min_Idx)
    );

    // Reference: first (lowest) address holding the smallest value.
    function automatic void ref_min(output logic [DATA_W-1:0] m, output logic [ADDR_W-1:0] ix);
        m  = '1;
        ix = '0;
        for (int i = 0; i < N; i++) if (mem[i] < m) begin m = mem[i]; ix = ADDR_W'(i); end
    endfunction

    // Pulses Go at the current negedge and observes 200 cycles; c = cycle after edge E_c.
    task automatic run_search(input int regen_cyc, output int done_cyc, output int done_cnt,
                              output int en_cnt, output int addr_err, output int busy_err,
                              output int stable_err);
        logic [DATA_W-1:0] p_sad = Min_SAD;
        logic [ADDR_W-1:0] p_idx = Min_Idx;
        done_cyc = -1; done_cnt = 0; en_cnt = 0; addr_err = 0; busy_err = 0; stable_err = 0;
        Go = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            Go = (c == regen_cyc);
            if (C_En) begin en_cnt++; if (int'(C_Addr) != c) addr_err++; end
            if (C_RW !== 1'b0) addr_err++;
            if (c <= 128 && Busy !== 1'b1) busy_err++;
            if (c >= 130 && Busy !== 1'b0) busy_err++;
            if (Done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (done_cnt == 0 && (Min_SAD !== p_sad || Min_Idx !== p_idx)) stable_err++;
        end
        Go = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++; if (C_En !== 1'b0)  begin n_fail++; $display("FAIL reset_en: got %0h expected 0", C_En); end
        n_checks++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", Busy); end
        n_checks++; if (Done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %0h expected 0", Done); end
        n_checks++; if (C_RW !== 1'b0)  begin n_fail++; $display("FAIL reset_rw: got %0h expected 0", C_RW); end
        n_checks++; if (C_Addr !== '0)  begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", C_Addr); end
        n_checks++; if (Min_SAD !== '0) begin n_fail++; $display("FAIL reset_sad: got %0h expected 0", Min_SAD); end
        n_checks++; if (Min_Idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0h expected 0", Min_Idx); end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_descending();
        int dc, dn, en, ae, be, se;
        for (int i = 0; i < N; i++) mem[i] = DATA_W'(N - i);
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (dc != 129)      begin n_fail++; $display("FAIL desc_latency: got %0d expected 129", dc); end
        n_checks++; if (dn != 1)        begin n_fail++; $display("FAIL desc_done_count: got %0d expected 1", dn); end
        n_checks++; if (en != N)        begin n_fail++; $display("FAIL desc_en_cycles: got %0d expected %0d", en, N); end
        n_checks++; if (ae != 0)        begin n_fail++; $display("FAIL desc_addr_order: got %0d errors expected 0", ae); end
        n_checks++; if (be != 0)        begin n_fail++; $display("FAIL desc_busy: got %0d errors expected 0", be); end
        n_checks++; if (se != 0)        begin n_fail++; $display("FAIL desc_stable: got %0d errors expected 0", se); end
        n_checks++; if (Min_SAD !== 1)  begin n_fail++; $display("FAIL desc_sad: got %0h expected 1", Min_SAD); end
        n_checks++; if (Min_Idx !== 127) begin n_fail++; $display("FAIL desc_idx: got %0d expected 127", Min_Idx); end
    endtask

    task automatic test_tie();
        int dc, dn, en, ae, be, se;
        for (int i = 0; i < N; i++) mem[i] = 5;
        mem[10] = 2; mem[40] = 2;
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (Min_SAD !== 2)  begin n_fail++; $display("FAIL tie_sad: got %0h expected 2", Min_SAD); end
        n_checks++; if (Min_Idx !== 10) begin n_fail++; $display("FAIL tie_idx: got %0d expected 10", Min_Idx); end
    endtask

    task automatic test_all_ones();
        int dc, dn, en, ae, be, se;
        for (int i = 0; i < N; i++) mem[i] = '1;
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (Min_SAD !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ones_sad: got %0h expected ffffffff", Min_SAD); end
        n_checks++; if (Min_Idx !== 0)  begin n_fail++; $display("FAIL ones_idx: got %0d expected 0", Min_Idx); end
        mem[0] = 0;
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (Min_SAD !== 0)  begin n_fail++; $display("FAIL zero0_sad: got %0h expected 0", Min_SAD); end
        n_checks++; if (Min_Idx !== 0)  begin n_fail++; $display("FAIL zero0_idx: got %0d expected 0", Min_Idx); end
    endtask

    task automatic test_random();
        int dc, dn, en, ae, be, se;
        logic [DATA_W-1:0] m;
        logic [ADDR_W-1:0] ix;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) mem[i] = (t % 2 == 0) ? $urandom_range(0, 40) : $urandom;
            ref_min(m, ix);
            run_search(-1, dc, dn, en, ae, be, se);
            n_checks++; if (dc != 129)     begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 129", t, dc); end
            n_checks++; if (Min_SAD !== m) begin n_fail++; $display("FAIL rand%0d_sad: got %0h expected %0h", t, Min_SAD, m); end
            n_checks++; if (Min_Idx !== ix) begin n_fail++; $display("FAIL rand%0d_idx: got %0d expected %0d", t, Min_Idx, ix); end
        end
    endtask

    task automatic test_go_ignored();
        int dc, dn, en, ae, be, se;
        for (int i = 0; i < N; i++) mem[i] = DATA_W'(N - i);
        run_search(30, dc, dn, en, ae, be, se);
        n_checks++; if (dn != 1)   begin n_fail++; $display("FAIL regen_done_count: got %0d expected 1", dn); end
        n_checks++; if (dc != 129) begin n_fail++; $display("FAIL regen_latency: got %0d expected 129", dc); end
        n_checks++; if (en != N)   begin n_fail++; $display("FAIL regen_en_cycles: got %0d expected %0d", en, N); end
    endtask

    task automatic test_reset_mid_search();
        int dc, dn, en, ae, be, se;
        int n_done = 0;
        logic [DATA_W-1:0] m;
        logic [ADDR_W-1:0] ix;
        Go = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            Go = 1'b0;
            if (Done) n_done++;
            if (c == 51) begin
                n_checks++; if (C_En !== 1'b0)  begin n_fail++; $display("FAIL abort_en: got %0h expected 0", C_En); end
                n_checks++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %0h expected 0", Busy); end
                n_checks++; if (C_Addr !== '0)  begin n_fail++; $display("FAIL abort_addr: got %0h expected 0", C_Addr); end
                n_checks++; if (Min_SAD !== '0) begin n_fail++; $display("FAIL abort_sad: got %0h expected 0", Min_SAD); end
                n_checks++; if (Min_Idx !== '0) begin n_fail++; $display("FAIL abort_idx: got %0d expected 0", Min_Idx); end
                Rst = 1'b0;
            end
            if (c == 50) Rst = 1'b1;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
        for (int i = 0; i < N; i++) mem[i] = $urandom_range(100, 100000);
        ref_min(m, ix);
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (dc != 129)      begin n_fail++; $display("FAIL after_abort_latency: got %0d expected 129", dc); end
        n_checks++; if (Min_SAD !== m)  begin n_fail++; $display("FAIL after_abort_sad: got %0h expected %0h", Min_SAD, m); end
        n_checks++; if (Min_Idx !== ix) begin n_fail++; $display("FAIL after_abort_idx: got %0d expected %0d", Min_Idx, ix); end
    endtask

    task automatic test_back_to_back();
        int dc, dn, en, ae, be, se;
        logic [DATA_W-1:0] m;
        logic [ADDR_W-1:0] ix;
        for (int i = 0; i < N; i++) mem[i] = $urandom_range(10, 1000);
        ref_min(m, ix);
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (Min_SAD !== m)  begin n_fail++; $display("FAIL b2b_first_sad: got %0h expected %0h", Min_SAD, m); end
        n_checks++; if (Min_Idx !== ix) begin n_fail++; $display("FAIL b2b_first_idx: got %0d expected %0d", Min_Idx, ix); end
        mem[77] = 3;
        run_search(-1, dc, dn, en, ae, be, se);
        n_checks++; if (se != 0)        begin n_fail++; $display("FAIL b2b_stable: got %0d errors expected 0", se); end
        n_checks++; if (Min_SAD !== 3)  begin n_fail++; $display("FAIL b2b_second_sad: got %0h expected 3", Min_SAD); end
        n_checks++; if (Min_Idx !== 77) begin n_fail++; $display("FAIL b2b_second_idx: got %0d expected 77", Min_Idx); end
    endtask

    task automatic test_go_held();
        int d_first = -1;
        int d_second = -1;
        int n_done = 0;
        logic en130 = 1'b1;
        logic en131 = 1'b0;
        Go = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk);
            if (Done) begin
                n_done++;
                if (d_first < 0) d_first = c; else if (d_second < 0) d_second = c;
            end
            if (c == 130) en130 = C_En;
            if (c == 131) en131 = C_En;
        end
        Go = 1'b0;
        n_checks++; if (d_first != 129)  begin n_fail++; $display("FAIL held_first_done: got %0d expected 129", d_first); end
        n_checks++; if (d_second != 260) begin n_fail++; $display("FAIL held_second_done: got %0d expected 260", d_second); end
        n_checks++; if (n_done != 2)     begin n_fail++; $display("FAIL held_done_count: got %0d expected 2", n_done); end
        n_checks++; if (en130 !== 1'b0)  begin n_fail++; $display("FAIL held_idle_gap: got %0h expected 0", en130); end
        n_checks++; if (en131 !== 1'b1)  begin n_fail++; $display("FAIL held_restart_en: got %0h expected 1", en131); end
        repeat (200) @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_descending();
        test_tie();
        test_all_ones();
        test_random();
        test_go_ignored();
        test_reset_mid_search();
        test_back_to_back();
        test_go_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
